instr_fetch_unit: RTL and testbench

- Instruction fetch front end. Produces the instruction word that the decode/control stage consumes.
- Issues in-order word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words in a small FIFO tagged with their PC, and presents them to decode with a valid/ready handshake.
- Applies PC redirects from the jump/branch path, squashing and discarding stale fetches.

---
 rtl/instr_fetch_unit_pkg.sv | 14 +
 rtl/instr_fetch_unit_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          IF_ENTRY_W       = 64;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, instr} entries; flush beats push.
module if_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = IF_ENTRY_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: in-order imem requests under a credit limit, PC-tagged
// instruction buffer toward decode, and redirect with stale-response dropping.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_misalign,
  output logic        o_resp_err
);

  localparam int          CW        = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d, last_pc_q;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic          misalign_q, resp_err_q;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_rdata;
  logic          credit_ok, fire, rsp_ok, rsp_drop, rsp_keep;
  logic [31:0]   target;

  assign target    = {i_alu_data[31:2], 2'b00};
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < DEPTH_LIM;
  assign fire      = o_imem_req & i_imem_gnt;
  // Responses with nothing outstanding are flagged and otherwise ignored.
  assign rsp_ok    = i_imem_rvalid & (outst_q != '0);
  assign rsp_drop  = rsp_ok & (drop_q != '0);
  assign rsp_keep  = rsp_ok & (drop_q == '0) & ~i_pc_sel;
  assign fifo_pop  = o_if_valid & i_id_ready;
  assign fifo_push = rsp_keep & (~fifo_full | fifo_pop);

  assign o_imem_req  = (state_q == FETCH) & credit_ok & ~i_pc_sel;
  assign o_imem_addr = pc_q;
  assign o_if_valid  = ~fifo_empty & ~i_pc_sel;
  assign o_if_instr  = fifo_empty ? NOP_INSTR : fifo_rdata[31:0];
  assign o_if_pc     = fifo_empty ? last_pc_q : fifo_rdata[63:32];
  assign o_misalign  = misalign_q;
  assign o_resp_err  = resp_err_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q + CW'(fire) - CW'(rsp_ok);
    drop_d    = drop_q - CW'(rsp_drop);
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (i_halt)  state_d = HALT;
      HALT:    if (!i_halt) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    if (fire)     pc_d      = pc_q + 32'd4;
    if (rsp_keep) resp_pc_d = resp_pc_q + 32'd4;
    // Every response still in flight after a redirect belongs to the old path.
    if (i_pc_sel) begin
      pc_d      = target;
      resp_pc_d = target;
      drop_d    = outst_q - CW'(rsp_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      misalign_q <= i_pc_sel & (|i_alu_data[1:0]);
      resp_err_q <= resp_err_q | (i_imem_rvalid & (outst_q == '0));
      if (!fifo_empty) last_pc_q <= fifo_rdata[63:32];
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IF_ENTRY_W)
  ) u_if_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (i_pc_sel),
    .wdata_i ({resp_pc_q, i_imem_rdata}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency memory responder.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n, halt, pc_sel, gnt, rvalid, id_ready;
  logic [31:0] alu_data, rdata;
  logic        req, if_valid, misalign, resp_err;
  logic [31:0] addr, if_instr, if_pc;

  int          n_checks = 0;
  int          n_errors = 0;
  int          halt_fires;
  bit          mem_hold;
  logic [31:0] pend_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_halt        (halt),
    .i_pc_sel      (pc_sel),
    .i_alu_data    (alu_data),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_if_valid    (if_valid),
    .i_id_ready    (id_ready),
    .o_if_instr    (if_instr),
    .o_if_pc       (if_pc),
    .o_misalign    (misalign),
    .o_resp_err    (resp_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: record handshakes seen this cycle, then model memory after the edge.
  task automatic tick();
    logic        fired;
    logic [31:0] faddr;
    fired = req & gnt;
    faddr = addr;
    if (if_valid && id_ready) begin
      got_pc.push_back(if_pc);
      got_instr.push_back(if_instr);
    end
    if (fired && halt) halt_fires++;
    @(posedge clk);
    #1;
    if (fired) pend_q.push_back(faddr);
    rvalid = 1'b0;
    rdata  = 32'h0;
    if (!mem_hold && pend_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend_q.pop_front());
    end
    #1;
  endtask

  task automatic wait_deliver(input string tag, input int n, input int budget);
    int cyc = 0;
    while (got_pc.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    check_val(tag, 32'(got_pc.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_req"},      req,      0);
    check_val({pfx, "_addr"},     addr,     32'h0);
    check_val({pfx, "_valid"},    if_valid, 0);
    check_val({pfx, "_instr"},    if_instr, NOP);
    check_val({pfx, "_pc"},       if_pc,    32'h0);
    check_val({pfx, "_misalign"}, misalign, 0);
    check_val({pfx, "_resp_err"}, resp_err, 0);
  endtask

  initial begin
    rst_n = 0; halt = 0; pc_sel = 0; alu_data = 0; gnt = 1;
    rvalid = 0; rdata = 0; id_ready = 1; mem_hold = 0; halt_fires = 0;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Free-running memory: first request one cycle after IDLE.
    rst_n = 1; #1;
    check_val("idle_req", req, 0);
    tick();
    check_val("first_req", req, 1);
    check_val("first_addr", addr, 32'h0);
    tick();
    check_val("rsp_latency_valid", if_valid, 0);
    tick();
    check_val("first_valid", if_valid, 1);
    check_val("first_pc", if_pc, 32'h0);
    check_val("first_instr", if_instr, 32'hC0DE_0000);
    wait_deliver("run_deliver", 3, 30);
    check_val("run_pc0", got_pc[0], 32'h0);
    check_val("run_pc1", got_pc[1], 32'h4);
    check_val("run_pc2", got_pc[2], 32'h8);
    check_val("run_instr2", got_instr[2], 32'hC0DE_0008);

    // Decode stall exhausts credit, then drains without loss or duplication.
    id_ready = 0;
    repeat (8) tick();
    check_val("stall_req", req, 0);
    check_val("stall_valid", if_valid, 1);
    check_val("stall_head_pc", if_pc, 32'(got_pc.size() * 4));
    id_ready = 1;
    wait_deliver("stall_drain", 12, 80);
    for (int i = 0; i < 12; i++) begin
      check_val($sformatf("seq_pc%0d", i), got_pc[i], 32'(i * 4));
      check_val($sformatf("seq_instr%0d", i), got_instr[i], 32'hC0DE_0000 | 32'(i * 4));
    end

    // Redirect to 0x100 with two requests in flight.
    mem_hold = 1;
    repeat (8) tick();
    check_val("hold_req", req, 0);
    check_val("hold_empty", if_valid, 0);
    got_pc.delete(); got_instr.delete();
    alu_data = 32'h100; pc_sel = 1;
    tick();
    pc_sel = 0; #1;
    check_val("redir_addr", addr, 32'h100);
    check_val("redir_valid", if_valid, 0);
    check_val("redir_aligned", misalign, 0);
    mem_hold = 0;
    wait_deliver("redir_deliver", 1, 30);
    check_val("redir_pc", got_pc[0], 32'h100);
    check_val("redir_instr", got_instr[0], 32'hC0DE_0100);

    // Misaligned redirect target.
    repeat (3) tick();
    alu_data = 32'h103; pc_sel = 1;
    tick();
    pc_sel = 0; #1;
    got_pc.delete(); got_instr.delete();
    check_val("mis_pulse", misalign, 1);
    check_val("mis_addr", addr, 32'h100);
    tick();
    check_val("mis_clear", misalign, 0);
    wait_deliver("mis_deliver", 1, 30);
    check_val("mis_pc", got_pc[0], 32'h100);

    // Halt with one request outstanding.
    gnt = 0; alu_data = 32'h200; pc_sel = 1;
    tick();
    pc_sel = 0;
    repeat (6) tick();
    check_val("wait_req", req, 1);
    check_val("wait_addr", addr, 32'h200);
    tick();
    check_val("wait_addr_stable", addr, 32'h200);
    mem_hold = 1; gnt = 1;
    tick();
    gnt = 0; halt = 1;
    tick();
    check_val("halt_req", req, 0);
    got_pc.delete(); got_instr.delete();
    halt_fires = 0; mem_hold = 0; gnt = 1;
    tick();
    tick();
    check_val("halt_rsp_valid", if_valid, 1);
    check_val("halt_rsp_pc", if_pc, 32'h200);
    check_val("halt_rsp_req", req, 0);
    tick();
    check_val("empty_valid", if_valid, 0);
    check_val("empty_instr", if_instr, NOP);
    check_val("empty_pc_hold", if_pc, 32'h200);
    repeat (4) tick();
    check_val("halt_no_fire", 32'(halt_fires), 32'd0);
    check_val("halt_got_pc", got_pc[0], 32'h200);
    halt = 0;
    tick();
    check_val("resume_req", req, 1);
    check_val("resume_addr", addr, 32'h204);
    wait_deliver("resume_deliver", 2, 30);
    check_val("resume_pc", got_pc[1], 32'h204);

    // Reset in mid-stream with buffered entries.
    id_ready = 0;
    repeat (4) tick();
    rst_n = 0;
    tick();
    pend_q.delete(); rvalid = 0; #1;
    id_ready = 1;
    check_reset_outputs("midrst");

    // Unsolicited response after reset.
    gnt = 0;
    tick();
    rst_n = 1;
    tick();
    rvalid = 1; rdata = 32'hDEAD_BEEF;
    tick();
    check_val("unsol_err", resp_err, 1);
    check_val("unsol_valid", if_valid, 0);
    repeat (3) tick();
    check_val("unsol_err_sticky", resp_err, 1);
    check_val("unsol_valid_late", if_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
